// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the unified memory port
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_dm
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_D = 2'd1;
  localparam logic [1:0] BUSY_I = 2'd2;

  logic [1:0] state;
  logic       discard;
  logic       grantFetch;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starveCnt;
  logic       starveHit;

  assign starveHit  = (starveCnt == 4'(STARVE_LIMIT));
  assign grantFetch = if_req & ~if_flush & (~dm_req | starveHit);

  // Counts data grants that overtook a live fetch request; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= 4'd0;
    end else if (state == IDLE) begin
      if (grantFetch)
        starveCnt <= 4'd0;
      else if (dm_req && if_req && !if_flush && !starveHit)
        starveCnt <= starveCnt + 4'd1;
    end
  end
`else
  logic [3:0] unusedStarveLimit;

  assign unusedStarveLimit = 4'(STARVE_LIMIT);
  assign grantFetch        = if_req & ~if_flush & ~dm_req;
`endif

  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      discard   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grantFetch) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            state    <= BUSY_I;
          end else if (dm_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= BUSY_D;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we)
              dm_rdata <= mem_rdata;
            dm_done <= 1'b1;
            state   <= IDLE;
          end
        end
        BUSY_I: begin
          // A redirect never aborts the bus cycle; it only drops the returned word.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!(discard || if_flush)) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            discard <= 1'b0;
            state   <= IDLE;
          end else if (if_flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_dm;

  typedef struct {
    bit          isData;
    logic [31:0] data;
  } sbEntry;

  sbEntry sbQ[$];
  int     checks   = 0;
  int     failures = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic waitReq(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    check({tag, "_grant"}, 32'(seen), 32'd1);
  endtask

  task automatic ackNow(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_done || dm_done) begin
      if (sbQ.size() == 0) begin
        check("sb_unexpected_done", {30'd0, if_done, dm_done}, 32'd0);
      end else begin
        sbEntry e;
        e = sbQ.pop_front();
        check("sb_port", {31'd0, dm_done}, {31'd0, e.isData});
        check("sb_data", e.isData ? dm_rdata : if_rdata, e.data);
      end
    end
  end

  initial begin
    sbEntry e;
    rst_n = 1'b0; if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_dones", {30'd0, if_done, dm_done}, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single load, ack two cycles after mem_req.
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    e.isData = 1; e.data = 32'hDEADBEEF; sbQ.push_back(e);
    waitReq("load");
    check("load_addr", mem_addr, 32'h100);
    check("load_we", 32'(mem_we), 0);
    check("load_stall", 32'(stall_dm), 1);
    @(negedge clk);
    ackNow(32'hDEADBEEF);
    check("load_done", 32'(dm_done), 1);
    check("load_stall_low", 32'(stall_dm), 0);
    dm_req = 0;
    @(negedge clk);
    check("load_done_pulse", 32'(dm_done), 0);

    // Simultaneous fetch and store: data first, fetch after one IDLE cycle.
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
    e.isData = 1; e.data = 32'hDEADBEEF; sbQ.push_back(e);
    waitReq("store");
    check("store_we", 32'(mem_we), 1);
    check("store_addr", mem_addr, 32'h200);
    check("store_wdata", mem_wdata, 32'h12345678);
    check("store_stall_if", 32'(stall_if), 1);
    ackNow(32'h00000BAD);
    check("store_done", 32'(dm_done), 1);
    check("idle_gap", 32'(mem_req), 0);
    dm_req = 0; dm_we = 0;
    e.isData = 0; e.data = 32'hE1A00000; sbQ.push_back(e);
    @(negedge clk);
    check("fetch_grant", 32'(mem_req), 1);
    check("fetch_addr", mem_addr, 32'h40);
    check("fetch_we", 32'(mem_we), 0);
    ackNow(32'hE1A00000);
    check("fetch_done", 32'(if_done), 1);
    if_req = 0;
    @(negedge clk);

    // Flushed fetch: bus cycle completes, word discarded.
    if_req = 1; if_addr = 32'h80;
    waitReq("flush");
    check("flush_addr", mem_addr, 32'h80);
    if_flush = 1; if_req = 0;
    @(negedge clk);
    if_flush = 0;
    @(negedge clk);
    ackNow(32'hE3A00001);
    check("flush_no_done", 32'(if_done), 0);
    check("flush_rdata_kept", if_rdata, 32'hE1A00000);
    check("flush_bus_idle", 32'(mem_req), 0);
    repeat (2) @(negedge clk);

    // Reset while BUSY_D; late ack afterwards must be ignored.
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    waitReq("rstmid");
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_req", 32'(mem_req), 0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_rdata", if_rdata | dm_rdata, 0);
    dm_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ackNow(32'hCAFEF00D);
    check("rstmid_no_done", {30'd0, if_done, dm_done}, 0);
    check("rstmid_idle", 32'(mem_req), 0);
    @(negedge clk);

    // Bus held stable across a 5-cycle ack delay while dm_addr moves.
    dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'hA5A5A5A5;
    e.isData = 1; e.data = 32'h0; sbQ.push_back(e);
    waitReq("hold");
    for (int i = 0; i < 5; i++) begin
      dm_addr  = 32'h500 + 32'(i);
      dm_wdata = 32'h11110000 + 32'(i);
      @(negedge clk);
      check("hold_addr", mem_addr, 32'h400);
      check("hold_wdata", mem_wdata, 32'hA5A5A5A5);
      check("hold_req", 32'(mem_req), 1);
    end
    ackNow(32'h0F0F0F0F);
    check("hold_done", 32'(dm_done), 1);
    dm_req = 0; dm_we = 0;
    @(negedge clk);

    // Starvation: dm_req held with a pending fetch.
    if_req = 1; if_addr = 32'hC0;
    dm_req = 1; dm_addr = 32'h600;
    for (int g = 0; g < 6; g++) begin
      bit expFetch;
`ifdef ARB_STARVE_GUARD_EN
      expFetch = (g == 4);
`else
      expFetch = 1'b0;
`endif
      e.isData = !expFetch; e.data = 32'h7000 + 32'(g); sbQ.push_back(e);
      waitReq("starve");
      check("starve_addr", mem_addr, expFetch ? 32'hC0 : 32'h600);
      ackNow(32'h7000 + 32'(g));
      if (expFetch) if_req = 0;
    end
    dm_req = 0;
`ifndef ARB_STARVE_GUARD_EN
    e.isData = 0; e.data = 32'h8000; sbQ.push_back(e);
    waitReq("starve_release");
    check("starve_release_addr", mem_addr, 32'hC0);
    ackNow(32'h8000);
    if_req = 0;
`endif
    repeat (3) @(negedge clk);
    check("sb_empty", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the pipelined ARM core between the fetch stage (instruction reads) and the memory stage (LDR/STR). It holds a granted transaction stable until the memory acknowledges, returns read data to the winning requester, and drives per-stage stall requests that the hazard unit ORs into StallF/StallD/FlushE. An optional starvation guard keeps fetch from being locked out by back-to-back data accesses.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (guard build only; legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch wants an instruction word
- if_addr  in  AW  fetch address (PCF)
- if_flush  in  1  discard the in-flight or pending fetch (branch taken / PC redirect)
- if_rdata  out  DW  instruction word, valid while if_done=1
- if_done  out  1  one-cycle pulse, fetch complete
- dm_req  in  1  memory stage wants an access
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid while dm_done=1
- dm_done  out  1  one-cycle pulse, data access complete
- mem_req  out  1  request to memory, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_ack  in  1  memory completes the current request this cycle
- mem_rdata  in  DW  read data, valid with mem_ack
- stall_if  out  1  to hazard unit: hold fetch stage
- stall_dm  out  1  to hazard unit: hold memory stage and everything behind it

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE: if dm_req -> latch dm_we/dm_addr/dm_wdata into mem_*, mem_req<=1, go BUSY_D. Else if if_req and not if_flush -> latch if_addr, mem_we<=0, go BUSY_I. Else stay.
- Priority: data over fetch (older instruction first).
- BUSY_x: mem_req, mem_we, mem_addr, mem_wdata held constant until mem_ack. On mem_ack: mem_req<=0, register mem_rdata into the owner's rdata, pulse owner's done next cycle, go IDLE.
- Flush: if_flush while in BUSY_I sets a discard flag; the memory transaction still completes (never aborted); on its ack if_done is suppressed and if_rdata is not updated. The flag clears on return to IDLE. if_flush in IDLE blocks granting fetch that cycle.
- Stores: dm_rdata is not updated; dm_done still pulses.
- stall_if = if_req & ~if_done (combinational). stall_dm = dm_req & ~dm_done. The requester holds req/addr stable while stalled.
- mem_ack outside BUSY_x is ignored.

## Timing
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, if_done, dm_done, discard flag, starvation counter = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- Grant latency: request sampled at edge t -> mem_req=1 after edge t.
- Completion: mem_ack sampled at edge t+k -> done=1 and rdata valid for exactly the cycle after edge t+k.
- Minimum access: 3 cycles from req to done (ack in first BUSY cycle). Back-to-back: one IDLE cycle between transactions.
- Simultaneous if_req and dm_req in IDLE: data wins; fetch stays stalled.
- Reset asserted mid-transaction: everything returns to reset values immediately; any late mem_ack after reset is ignored (state IDLE).

## Configuration
- ARB_STARVE_GUARD_EN defined: 4-bit counter increments each time IDLE grants data while if_req=1 and if_flush=0, saturating at STARVE_LIMIT. Counter reset to 0 on any fetch grant. When the counter equals STARVE_LIMIT and if_req=1, fetch wins over dm_req.
- Not defined: no counter; pure data-over-fetch priority; STARVE_LIMIT unused.

## Test plan
- Single load, ack 2 cycles after mem_req: dm_addr=0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, dm_done pulse 1 cycle, dm_rdata=0xDEADBEEF, stall_dm low after done.
- Simultaneous if_req (0x40) and dm_req store (0x200, 0x12345678) -> data granted first with mem_we=1, mem_wdata=0x12345678; fetch granted after an IDLE cycle; if_done after second ack.
- Fetch at 0x80, if_flush asserted in BUSY_I, ack returns 0xE3A00001 -> if_done never pulses, if_rdata unchanged, FSM back to IDLE.
- rst_n dropped while BUSY_D with mem_req=1 -> mem_req=0 asynchronously; mem_ack after reset release produces no done.
- Guard build, STARVE_LIMIT=4, dm_req held high with if_req high -> 4 data grants, then fetch granted; non-guard build -> fetch never granted until dm_req drops.
- mem_addr/mem_wdata held constant across 5-cycle ack delay while dm_addr changes -> no change on memory bus.
